told_retire_queue: RTL and testbench

- In-order circular buffer that records each dispatched instruction's previous physical tag (Told) at dispatch.
- Marks entries complete on writeback.
- Returns the Told tags of the oldest completed entries, up to N per cycle, on the freelist retire interface (retire_en / retire_reg).
- Sits between dispatch/rename and the physical-register freelist; it is the producer side of the freelist retire interface.

---
 rtl/told_retire_queue_if.sv | 41 ++++
 rtl/told_retire_queue.sv | 145 ++++++++++++++
 tb/tb_told_retire_queue.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/told_retire_queue_if.sv
// +----------------------------------------------------------------------------+
// | told_retire_queue_if                                                       |
// | Dispatch / writeback / flush / freelist-retire bundle for the Told queue.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

interface told_retire_queue_if #(
  parameter int N        = 2,
  parameter int DEPTH    = 16,
  parameter int PR_COUNT = 64
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int TAG_W = $clog2(PR_COUNT);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [N-1:0]             disp_valid;
  logic [N-1:0]             disp_has_dest;
  logic [N-1:0][TAG_W-1:0]  disp_told;
  logic [N-1:0][IDX_W-1:0]  disp_idx;
  logic [CNT_W-1:0]         free_slots;
  logic [N-1:0]             complete_valid;
  logic [N-1:0][IDX_W-1:0]  complete_idx;
  logic                     flush;
  logic [N-1:0]             retire_en;
  logic [N-1:0][TAG_W-1:0]  retire_reg;
  logic [N-1:0]             retire_valid;
  logic                     disp_overflow;

  modport master (
    output disp_valid, disp_has_dest, disp_told, complete_valid, complete_idx, flush,
    input  disp_idx, free_slots, retire_en, retire_reg, retire_valid, disp_overflow
  );

  modport slave (
    input  disp_valid, disp_has_dest, disp_told, complete_valid, complete_idx, flush,
    output disp_idx, free_slots, retire_en, retire_reg, retire_valid, disp_overflow
  );
endinterface

`default_nettype wire

// File: rtl/told_retire_queue.sv
// +----------------------------------------------------------------------------+
// | told_retire_queue                                                          |
// | In-order Told buffer; returns Told tags of oldest completed entries to the |
// | freelist. TRQ_COMPLETE_BYPASS_EN: same-cycle completion-to-retire path.    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module told_retire_queue #(
  parameter int N        = 2,
  parameter int DEPTH    = 16,
  parameter int PR_COUNT = 64
) (
  input  wire logic           clock,
  input  wire logic           reset_n,
  told_retire_queue_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int TAG_W = $clog2(PR_COUNT);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

  logic [IDX_W-1:0] r_head;
  logic [IDX_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;
  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_done;
  logic [DEPTH-1:0] r_has_dest;
  logic [TAG_W-1:0] r_told [DEPTH];
  logic             r_overflow;

  logic [CNT_W-1:0] w_free;
  logic [CNT_W-1:0] w_k;
  logic [CNT_W-1:0] w_r;
  logic             w_accept;
  logic             w_run;
  logic [DEPTH-1:0] w_disp_hit;
  logic [DEPTH-1:0] w_comp_hit;
  logic [DEPTH-1:0] w_ret_hit;
  logic [DEPTH-1:0] w_done_eff;

  assign w_free             = C_DEPTH - r_count;
  assign bus.free_slots     = w_free;
  assign bus.disp_overflow  = r_overflow;

  for (genvar g = 0; g < N; g++) begin : g_disp_idx
    assign bus.disp_idx[g] = r_tail + IDX_W'(g);
  end

  // Dispatch is all-or-nothing: a partial accept would break in-order tagging.
  always_comb begin : dispatch_calc
    w_k = '0;
    for (int i = 0; i < N; i++) begin
      w_k = w_k + CNT_W'(bus.disp_valid[i]);
    end
    w_accept   = !bus.flush && (w_k <= w_free);
    w_disp_hit = '0;
    for (int i = 0; i < N; i++) begin
      if (w_accept && bus.disp_valid[i]) begin
        w_disp_hit[r_tail + IDX_W'(i)] = 1'b1;
      end
    end
  end

  always_comb begin : complete_calc
    w_comp_hit = '0;
    for (int i = 0; i < N; i++) begin
      if (bus.complete_valid[i] && !bus.flush) begin
        w_comp_hit[bus.complete_idx[i]] = 1'b1;
      end
    end
    w_comp_hit = w_comp_hit & r_valid & ~w_disp_hit;
`ifdef TRQ_COMPLETE_BYPASS_EN
    w_done_eff = r_done | w_comp_hit;
`else
    w_done_eff = r_done;
`endif
  end

  // Retire walks from head and stops at the first entry that is not done.
  always_comb begin : retire_calc
    w_r              = '0;
    w_run            = !bus.flush;
    w_ret_hit        = '0;
    bus.retire_valid = '0;
    bus.retire_en    = '0;
    bus.retire_reg   = '0;
    for (int i = 0; i < N; i++) begin
      if (w_run && (CNT_W'(i) < r_count) && r_valid[r_head + IDX_W'(i)]
          && w_done_eff[r_head + IDX_W'(i)]) begin
        w_r                          = w_r + CNT_W'(1);
        w_ret_hit[r_head + IDX_W'(i)] = 1'b1;
        bus.retire_valid[i]          = 1'b1;
        bus.retire_en[i]             = r_has_dest[r_head + IDX_W'(i)];
        bus.retire_reg[i]            = r_has_dest[r_head + IDX_W'(i)]
                                       ? r_told[r_head + IDX_W'(i)] : '0;
      end else begin
        w_run = 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin : state_reg
    if (!reset_n) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_valid    <= '0;
      r_done     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (!bus.flush && (w_k > w_free)) begin
        r_overflow <= 1'b1;
      end
      if (bus.flush) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
        r_valid <= '0;
        r_done  <= '0;
      end else begin
        r_head  <= r_head + w_r[IDX_W-1:0];
        if (w_accept) begin
          r_tail <= r_tail + w_k[IDX_W-1:0];
        end
        r_count <= r_count + (w_accept ? w_k : '0) - w_r;
        r_valid <= (r_valid & ~w_ret_hit) | w_disp_hit;
        r_done  <= (r_done & ~w_ret_hit & ~w_disp_hit) | (w_comp_hit & ~w_ret_hit);
      end
    end
  end

  // Payload is only observed behind valid/done, so it carries no reset.
  always_ff @(posedge clock) begin : payload_reg
    for (int i = 0; i < N; i++) begin
      if (w_accept && bus.disp_valid[i]) begin
        r_told[r_tail + IDX_W'(i)]     <= bus.disp_told[i];
        r_has_dest[r_tail + IDX_W'(i)] <= bus.disp_has_dest[i];
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_told_retire_queue.sv
// +----------------------------------------------------------------------------+
// | tb_told_retire_queue                                                       |
// | Directed and random stimulus against a queue-based model of the Told queue.|
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_told_retire_queue;
  localparam int N        = 2;
  localparam int DEPTH    = 16;
  localparam int PR_COUNT = 64;
`ifdef TRQ_COMPLETE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clock   = 1'b0;
  logic reset_n = 1'b1;
  always #5 clock = ~clock;

  told_retire_queue_if #(.N(N), .DEPTH(DEPTH), .PR_COUNT(PR_COUNT)) bus ();

  told_retire_queue #(.N(N), .DEPTH(DEPTH), .PR_COUNT(PR_COUNT)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    int idx;
    int told;
    bit has_dest;
    bit done;
  } ent_t;

  ent_t q[$];
  int   m_head = 0;
  bit   m_ovf  = 1'b0;
  int   mk, mr, mtail;
  bit   macc;
  int   checks = 0;
  int   errors = 0;

  function automatic bit comp_hits(input int idx);
    for (int l = 0; l < N; l++)
      if (bus.complete_valid[l] && int'(bus.complete_idx[l]) == idx) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int model_k();
    int k = 0;
    for (int l = 0; l < N; l++) k += int'(bus.disp_valid[l]);
    return k;
  endfunction

  // Oldest-first run of done entries (bypass build also counts this cycle's completions).
  function automatic int model_r();
    int r = 0;
    if (bus.flush) return 0;
    while (r < N && r < q.size() && (q[r].done || (BYP && comp_hits(q[r].idx)))) r++;
    return r;
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q.delete();
      m_head = 0;
      m_ovf  = 1'b0;
    end else begin
      mk    = model_k();
      mr    = model_r();
      mtail = (m_head + q.size()) % DEPTH;
      macc  = !bus.flush && (mk <= DEPTH - q.size());
      if (!bus.flush && mk > DEPTH - q.size()) m_ovf = 1'b1;
      if (bus.flush) begin
        q.delete();
        m_head = 0;
      end else begin
        foreach (q[i]) if (comp_hits(q[i].idx)) q[i].done = 1'b1;
        repeat (mr) void'(q.pop_front());
        m_head = (m_head + mr) % DEPTH;
        if (macc)
          for (int l = 0; l < N; l++)
            if (bus.disp_valid[l])
              q.push_back('{idx: (mtail + l) % DEPTH, told: int'(bus.disp_told[l]),
                            has_dest: bus.disp_has_dest[l], done: 1'b0});
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int r;
    r = model_r();
    for (int l = 0; l < N; l++) begin
      logic v, en;
      int   rg;
      v  = (l < r);
      en = 1'b0;
      rg = 0;
      if (v) begin
        en = q[l].has_dest;
        rg = en ? q[l].told : 0;
      end
      chk($sformatf("retire_valid[%0d]", l), 32'(bus.retire_valid[l]), 32'(v));
      chk($sformatf("retire_en[%0d]", l), 32'(bus.retire_en[l]), 32'(en));
      chk($sformatf("retire_reg[%0d]", l), 32'(bus.retire_reg[l]), rg);
      chk($sformatf("disp_idx[%0d]", l), 32'(bus.disp_idx[l]), (m_head + q.size() + l) % DEPTH);
    end
    chk("free_slots", 32'(bus.free_slots), DEPTH - q.size());
    chk("disp_overflow", 32'(bus.disp_overflow), 32'(m_ovf));
  endtask

  task automatic tick();
    @(negedge clock);
    check_outputs();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.disp_valid     = '0;
    bus.disp_has_dest  = '0;
    bus.disp_told      = '0;
    bus.complete_valid = '0;
    bus.complete_idx   = '0;
    bus.flush          = 1'b0;
  endtask

  task automatic disp(input int n, input logic [1:0] hd, input int t0, input int t1);
    bus.disp_valid    = (n == 0) ? 2'b00 : (n == 1) ? 2'b01 : 2'b11;
    bus.disp_has_dest = hd;
    bus.disp_told[0]  = 6'(t0);
    bus.disp_told[1]  = 6'(t1);
  endtask

  task automatic comp(input logic [1:0] v, input int i0, input int i1);
    bus.complete_valid  = v;
    bus.complete_idx[0] = 4'(i0);
    bus.complete_idx[1] = 4'(i1);
  endtask

  task automatic lit_retire(input string name, input int rv, input int en, input int r0, input int r1);
    chk({name, "_rv"}, 32'(bus.retire_valid), rv);
    chk({name, "_en"}, 32'(bus.retire_en), en);
    chk({name, "_reg0"}, 32'(bus.retire_reg[0]), r0);
    chk({name, "_reg1"}, 32'(bus.retire_reg[1]), r1);
  endtask

  task automatic do_reset();
    idle();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    int pc;
    idle();
    #1 reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    chk("rst_free", 32'(bus.free_slots), 16);
    chk("rst_rv", 32'(bus.retire_valid), 0);

    // First dispatch pair and out-of-order completion
    disp(2, 2'b11, 40, 41);
    #1 chk("t1_idx0", 32'(bus.disp_idx[0]), 0);
    chk("t1_idx1", 32'(bus.disp_idx[1]), 1);
    tick(); idle();
    #1 chk("t1_free", 32'(bus.free_slots), 14);
    comp(2'b01, 1, 0);
    #1 chk("t2_nohead", 32'(bus.retire_valid), 0);
    tick();
    comp(2'b01, 0, 0);
`ifdef TRQ_COMPLETE_BYPASS_EN
    #1 lit_retire("t2", 3, 3, 40, 41);
`endif
    tick(); idle();
`ifndef TRQ_COMPLETE_BYPASS_EN
    #1 lit_retire("t2", 3, 3, 40, 41);
`endif
    tick();
    #1 chk("t2_free", 32'(bus.free_slots), 16);

    // Lane without destination retires but returns no tag
    disp(2, 2'b01, 50, 7);
    tick(); idle();
    comp(2'b11, 2, 3);
`ifdef TRQ_COMPLETE_BYPASS_EN
    #1 lit_retire("t3", 3, 1, 50, 0);
`endif
    tick(); idle();
`ifndef TRQ_COMPLETE_BYPASS_EN
    #1 lit_retire("t3", 3, 1, 50, 0);
`endif
    tick();

    // Fill to DEPTH, overflow, then dispatch alongside retirement
    for (int j = 0; j < 8; j++) begin
      disp(2, 2'b11, 10 + 2 * j, 11 + 2 * j);
      tick();
    end
    idle();
    #1 chk("t4_full", 32'(bus.free_slots), 0);
    disp(1, 2'b01, 33, 0);
    #1 chk("t4_ovf_pre", 32'(bus.disp_overflow), 0);
    tick(); idle();
    #1 chk("t4_ovf", 32'(bus.disp_overflow), 1);
    chk("t4_free", 32'(bus.free_slots), 0);
    comp(2'b11, 4, 5);
    tick(); idle();
`ifndef TRQ_COMPLETE_BYPASS_EN
    tick();
`endif
    #1 chk("t4_free14", 32'(bus.free_slots), 2);
    comp(2'b11, 6, 7);
`ifndef TRQ_COMPLETE_BYPASS_EN
    tick(); idle();
`endif
    disp(2, 2'b11, 60, 61);
    #1 chk("t4_sim_idx0", 32'(bus.disp_idx[0]), 4);
    chk("t4_sim_idx1", 32'(bus.disp_idx[1]), 5);
    chk("t4_sim_rv", 32'(bus.retire_valid), 3);
    tick(); idle();
    #1 chk("t4_sim_free", 32'(bus.free_slots), 2);

    // Flush masks retirement and empties the queue
    do_reset();
    for (int j = 0; j < 3; j++) begin
      disp(2, 2'b11, 20 + j, 30 + j);
      tick();
    end
    idle();
    comp(2'b11, 1, 2);
    tick(); idle();
    bus.flush = 1'b1;
    comp(2'b01, 0, 0);
    #1 chk("t5_flush_rv", 32'(bus.retire_valid), 0);
    chk("t5_flush_en", 32'(bus.retire_en), 0);
    chk("t5_flush_free", 32'(bus.free_slots), 10);
    tick(); idle();
    comp(2'b01, 3, 0);
    #1 chk("t5_free", 32'(bus.free_slots), 16);
    chk("t5_tail", 32'(bus.disp_idx[0]), 0);
    tick(); idle();
    disp(2, 2'b11, 44, 45);
    tick(); idle();
    comp(2'b01, 1, 0);
    #1 chk("t5_stale", 32'(bus.retire_valid), 0);
    tick(); idle();

    // Reset while tags are about to retire
    disp(2, 2'b11, 46, 47);
    tick(); idle();
    comp(2'b11, 2, 3);
    tick(); idle();
    comp(2'b01, 0, 0);
`ifndef TRQ_COMPLETE_BYPASS_EN
    tick(); idle();
`endif
    #1 chk("t6_pre_rv", 32'(bus.retire_valid), 3);
    reset_n = 1'b0;
    #1 lit_retire("t6_rst", 0, 0, 0, 0);
    chk("t6_rst_free", 32'(bus.free_slots), 16);
    tick();
    idle();
    reset_n = 1'b1;
    #1 chk("t6_free", 32'(bus.free_slots), 16);
    chk("t6_rv", 32'(bus.retire_valid), 0);
    tick();

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      pc = (c < 2000) ? 30 : 70;
      disp($urandom_range(0, N), 2'($urandom_range(0, 3)),
           $urandom_range(0, PR_COUNT - 1), $urandom_range(0, PR_COUNT - 1));
      for (int l = 0; l < N; l++) begin
        bus.complete_valid[l] = ($urandom_range(0, 99) < pc);
        if (q.size() > 0 && $urandom_range(0, 4) != 0)
          bus.complete_idx[l] = 4'(q[$urandom_range(0, q.size() - 1)].idx);
        else
          bus.complete_idx[l] = 4'($urandom_range(0, DEPTH - 1));
      end
      bus.flush = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 499) == 0) begin
        reset_n = 1'b0;
        #2 reset_n = 1'b1;
      end
      tick();
    end
    idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
